// File: rtl/dct_quant_zigzag.sv
// -----------------------------------------------------------------------------
// dct_quant_zigzag
//
// Purpose:
//   Sits downstream of the 2-D DCT. Accepts 12-bit signed DCT coefficients in
//   raster order (one per enabled cycle, 64 per 8x8 block), stores each block
//   in one half of a 2x64 ping-pong buffer, then reads it back in JPEG zigzag
//   order. Each coefficient is quantized by the JPEG luminance table through a
//   reciprocal multiply with round-half-away-from-zero. Input and output run
//   concurrently at one sample per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   enb        data_in valid; the sample is accepted at the rising edge
//   data_in    DCT coefficient, raster order (row-major, u fastest)
//   data_out   quantized coefficient, zigzag order
//   out_valid  data_out valid
//   blk_start  high with out_valid on zigzag index 0 (DC) of each block
//
// Optional build macro QTABLE_LOAD_EN:
//   When defined, adds qt_we / qt_addr (raster index) / qt_data (reciprocal)
//   and turns the reciprocal table into a register file reset to the default
//   luminance reciprocals. A write is seen by any read issued on or after the
//   edge following qt_we. When undefined the table is a constant ROM.
//
// Timing (continuous enb): the edge accepting raster sample 63 hands the bank
// to the read side; output i is registered 2+i edges later, so sample 0 to
// output 0 is 65 edges.
// -----------------------------------------------------------------------------
module dct_quant_zigzag #(
    parameter int DIN_W   = 12,
    parameter int DOUT_W  = 12,
    parameter int RECIP_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enb,
    input  logic signed [DIN_W-1:0]  data_in,
`ifdef QTABLE_LOAD_EN
    input  logic                     qt_we,
    input  logic [5:0]               qt_addr,
    input  logic [RECIP_W:0]         qt_data,
`endif
    output logic signed [DOUT_W-1:0] data_out,
    output logic                     out_valid,
    output logic                     blk_start
);

    // -------------------------------------------------------------------------
    // Constant tables
    // -------------------------------------------------------------------------

    // ITU-T T.81 Annex K luminance quantization table, raster order.
    localparam int Q_LUM [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    // Reciprocals need RECIP_W+1 bits so that Q=1 (2^RECIP_W) is representable.
    typedef logic [63:0][RECIP_W:0] recip_tab_t;
    typedef logic [63:0][5:0]       zz_tab_t;

    // recip[k] = round(2^RECIP_W / Q[k]), evaluated at elaboration time.
    function automatic recip_tab_t gen_recip_tab();
        recip_tab_t t;
        longint     q;
        t = '0;
        for (int k = 0; k < 64; k++) begin
            q = longint'(Q_LUM[k[5:0]]);
            t[k[5:0]] = (RECIP_W+1)'(((longint'(1) << RECIP_W) + q / 2) / q);
        end
        return t;
    endfunction

    // Zigzag scan: walk the 15 anti-diagonals s = row + col. Odd diagonals are
    // traversed with the row rising, even diagonals with the row falling.
    function automatic zz_tab_t gen_zz_tab();
        zz_tab_t t;
        int      n;
        int      lo;
        int      hi;
        int      r;
        t = '0;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            lo = (s > 7) ? s - 7 : 0;
            hi = (s < 7) ? s : 7;
            for (int j = 0; j <= hi - lo; j++) begin
                r = (s % 2 == 1) ? lo + j : hi - j;
                t[n[5:0]] = 6'(r * 8 + (s - r));
                n++;
            end
        end
        return t;
    endfunction

    localparam recip_tab_t RECIP_DEF = gen_recip_tab();
    localparam zz_tab_t    ZZ_TAB    = gen_zz_tab();

    // Datapath widths: unsigned product, rounded magnitude, signed result wide
    // enough for both the negated magnitude and the saturation bounds.
    localparam int PW = DIN_W + RECIP_W + 1;
    localparam int WW = (DIN_W + 2 > DOUT_W) ? DIN_W + 2 : DOUT_W;

    localparam logic [PW-1:0]        RND    = PW'(1) << (RECIP_W - 1);
    localparam logic signed [WW-1:0] SAT_HI = WW'((longint'(1) <<< (DOUT_W - 1)) - longint'(1));
    localparam logic signed [WW-1:0] SAT_LO = ~SAT_HI;

    // -------------------------------------------------------------------------
    // Reciprocal table source
    // -------------------------------------------------------------------------
    recip_tab_t w_recip_tab;

`ifdef QTABLE_LOAD_EN
    recip_tab_t r_recip_tab;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_recip_tab <= RECIP_DEF;
        end else if (qt_we) begin
            r_recip_tab[qt_addr] <= qt_data;
        end
    end

    assign w_recip_tab = r_recip_tab;
`else
    assign w_recip_tab = RECIP_DEF;
`endif

    // -------------------------------------------------------------------------
    // Write side
    // -------------------------------------------------------------------------
    logic [5:0] r_wr_idx;
    logic       r_wr_bank;
    logic       w_handoff;

    // The edge writing raster index 63 completes a bank and starts its readout.
    assign w_handoff = enb && (r_wr_idx == 6'd63);

    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbours regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx  <= '0;
            r_wr_bank <= 1'b0;
        end else if (enb) begin
            r_wr_idx <= r_wr_idx + 6'd1;
            if (r_wr_idx == 6'd63) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Read-side sequencer
    // -------------------------------------------------------------------------
    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_e;

    rd_state_e r_rd_state;
    rd_state_e w_rd_state_nxt;
    logic [5:0] r_rd_idx;
    logic [5:0] w_rd_idx_nxt;
    logic       r_rd_bank;
    logic       w_rd_bank_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_state <= RD_IDLE;
            r_rd_idx   <= '0;
            r_rd_bank  <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_rd_idx   <= w_rd_idx_nxt;
            r_rd_bank  <= w_rd_bank_nxt;
        end
    end

    // NOTE: every output of this block gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_rd_idx_nxt   = r_rd_idx;
        w_rd_bank_nxt  = r_rd_bank;
        if (w_handoff) begin
            // Takes priority: when it coincides with issuing index 63 of the
            // other bank, the new bank starts on the next cycle without a gap.
            w_rd_state_nxt = RD_RUN;
            w_rd_idx_nxt   = 6'd0;
            w_rd_bank_nxt  = r_wr_bank;
        end else if (r_rd_state == RD_RUN) begin
            w_rd_idx_nxt = r_rd_idx + 6'd1;
            if (r_rd_idx == 6'd63) begin
                w_rd_state_nxt = RD_IDLE;
            end
        end
    end

    // Zigzag position -> raster address, shared by RAM and reciprocal lookup.
    logic [5:0] w_rd_addr;
    assign w_rd_addr = ZZ_TAB[r_rd_idx];

    // -------------------------------------------------------------------------
    // Ping-pong buffer and stage 1 (RAM read + reciprocal fetch)
    // -------------------------------------------------------------------------
    logic signed [DIN_W-1:0] r_mem [0:127];
    logic signed [DIN_W-1:0] r_s1_data;
    logic [RECIP_W:0]        r_s1_recip;
    logic                    r_s1_valid;
    logic                    r_s1_first;

    // NOTE: the buffer and its read register carry no reset so they map onto
    // block RAM; their contents are qualified by r_s1_valid instead.
    always_ff @(posedge clk) begin
        if (enb) begin
            r_mem[{r_wr_bank, r_wr_idx}] <= data_in;
        end
        r_s1_data  <= r_mem[{r_rd_bank, w_rd_addr}];
        r_s1_recip <= w_recip_tab[w_rd_addr];
    end

    // -------------------------------------------------------------------------
    // Quantizer: m = (|c| * r + 2^(RECIP_W-1)) >> RECIP_W, then re-apply sign.
    // Applying the sign after rounding the magnitude gives round-half-away.
    // -------------------------------------------------------------------------
    logic [DIN_W-1:0]        w_abs;
    logic [PW-1:0]           w_prod;
    logic [DIN_W:0]          w_mag;
    logic signed [WW-1:0]    w_mag_ext;
    logic signed [WW-1:0]    w_val;
    logic signed [DOUT_W-1:0] w_q;

    always_comb begin
        // -2^(DIN_W-1) negates to itself, whose unsigned reading is the
        // correct magnitude, so DIN_W bits suffice.
        w_abs     = r_s1_data[DIN_W-1] ? $unsigned(-r_s1_data) : $unsigned(r_s1_data);
        w_prod    = PW'(w_abs) * PW'(r_s1_recip);
        w_mag     = (DIN_W+1)'((w_prod + RND) >> RECIP_W);
        w_mag_ext = $signed(WW'(w_mag));
        w_val     = r_s1_data[DIN_W-1] ? -w_mag_ext : w_mag_ext;

        w_q = DOUT_W'(w_val);
        if (w_val > SAT_HI) begin
            w_q = SAT_HI[DOUT_W-1:0];
        end else if (w_val < SAT_LO) begin
            w_q = SAT_LO[DOUT_W-1:0];
        end
    end

    // -------------------------------------------------------------------------
    // Stage 1 control and stage 2 output register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            blk_start  <= 1'b0;
        end else begin
            r_s1_valid <= (r_rd_state == RD_RUN);
            r_s1_first <= (r_rd_state == RD_RUN) && (r_rd_idx == 6'd0);
            out_valid  <= r_s1_valid;
            blk_start  <= r_s1_first;
            if (r_s1_valid) begin
                data_out <= w_q;
            end
        end
    end

endmodule

// File: tb/tb_dct_quant_zigzag.sv
module tb_dct_quant_zigzag;

    localparam int DIN_W   = 12;
    localparam int DOUT_W  = 12;
    localparam int RECIP_W = 16;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic                     enb = 1'b0;
    logic signed [DIN_W-1:0]  data_in = '0;
    logic signed [DOUT_W-1:0] data_out;
    logic                     out_valid;
    logic                     blk_start;

    dct_quant_zigzag #(
        .DIN_W   (DIN_W),
        .DOUT_W  (DOUT_W),
        .RECIP_W (RECIP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enb       (enb),
        .data_in   (data_in),
        .data_out  (data_out),
        .out_valid (out_valid),
        .blk_start (blk_start)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference data: JPEG zigzag order and luminance table as literals
    // ------------------------------------------------------------------
    localparam int ZZ_REF [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    localparam int Q_REF [64] = '{
        16,  11,  10,  16,  24,  40,  51,  61,
        12,  12,  14,  19,  26,  58,  60,  55,
        14,  13,  16,  24,  40,  57,  69,  56,
        14,  17,  22,  29,  51,  87,  80,  62,
        18,  22,  37,  56,  68, 109, 103,  77,
        24,  35,  55,  64,  81, 104, 113,  92,
        49,  64,  78,  87, 103, 121, 120, 101,
        72,  92,  95,  98, 112, 100, 103,  99
    };

    // Quantize coefficient c located at raster position k.
    function automatic int model_q(input int c, input int k);
        int q, r, a, m, v;
        q = Q_REF[k];
        r = ((1 << RECIP_W) + q / 2) / q;
        a = (c < 0) ? -c : c;
        m = (a * r + (1 << (RECIP_W - 1))) >> RECIP_W;
        v = (c < 0) ? -m : m;
        if (v > (1 << (DOUT_W - 1)) - 1) v = (1 << (DOUT_W - 1)) - 1;
        if (v < -(1 << (DOUT_W - 1)))    v = -(1 << (DOUT_W - 1));
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    typedef struct {
        int data;
        int bs;
        int stamp;
    } cap_t;

    typedef struct {
        int c;
        int exp0;
    } vec_t;

    int   total = 0;
    int   bad   = 0;
    int   edge_cnt = 0;
    int   s0_edge = 0;
    int   cur_blk [64];
    int   exp_q [$];
    cap_t cap_q [$];
    vec_t vecs [10];

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Outputs are sampled on the falling edge, stamped with the rising edge
    // that produced them.
    always @(negedge clk) begin
        if (out_valid) begin
            cap_q.push_back('{int'(data_out), int'(blk_start), edge_cnt});
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            enb = 1'b0;
        end
    endtask

    // Drive the first n samples of cur_blk; optional enb gap after sample gap_at.
    task automatic send_block(input int n, input int gap_at, input int gap_len);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enb     = 1'b1;
            data_in = DIN_W'(cur_blk[i]);
            if (i == 0) s0_edge = edge_cnt + 1;
            if (i == gap_at) begin
                repeat (gap_len) begin
                    @(negedge clk);
                    enb = 1'b0;
                end
            end
        end
    endtask

    task automatic expect_block();
        for (int i = 0; i < 64; i++) begin
            exp_q.push_back(model_q(cur_blk[ZZ_REF[i]], ZZ_REF[i]));
        end
    endtask

    task automatic clear_all();
        cap_q.delete();
        exp_q.delete();
    endtask

    // Wait (bounded) for all expected outputs, then compare values, block
    // start flags and edge stamps (latency plus contiguity).
    task automatic compare_outputs(input string name, input int first_edge);
        int n;
        int budget;
        n = exp_q.size();
        budget = 0;
        while (cap_q.size() < n && budget < 400) begin
            @(negedge clk);
            enb = 1'b0;
            budget++;
        end
        idle(4);
        check($sformatf("%s count", name), cap_q.size(), n);
        for (int i = 0; i < n && i < cap_q.size(); i++) begin
            check($sformatf("%s data[%0d]", name, i), cap_q[i].data, exp_q[i]);
            check($sformatf("%s blk_start[%0d]", name, i), cap_q[i].bs, (i % 64 == 0) ? 1 : 0);
            check($sformatf("%s edge[%0d]", name, i), cap_q[i].stamp, first_edge + i);
        end
    endtask

    function automatic int rnd_coef();
        return int'($urandom_range(4095, 0)) - 2048;
    endfunction

    initial begin
        int first_s0;

        // Watchdog: the run is a few thousand cycles.
        fork
            begin
                #1000000;
                $display("FAIL watchdog: simulation did not finish in time");
                $fatal(1, "watchdog expired");
            end
        join_none

        vecs[0] = '{-24,   -2};
        vecs[1] = '{ 24,    2};
        vecs[2] = '{ -8,   -1};
        vecs[3] = '{  8,    1};
        vecs[4] = '{-2048, -128};
        vecs[5] = '{2047,  128};
        vecs[6] = '{1024,   64};
        vecs[7] = '{ -7,    0};
        vecs[8] = '{ 40,    3};
        vecs[9] = '{ -1,    0};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check("reset out_valid", int'(out_valid), 0);
        check("reset blk_start", int'(blk_start), 0);
        check("reset data_out", int'(data_out), 0);
        rst = 1'b0;
        idle(2);

        // ---- 1: DC-only block ----
        clear_all();
        for (int k = 0; k < 64; k++) cur_blk[k] = 0;
        cur_blk[0] = 1024;
        exp_q.push_back(64);
        for (int i = 1; i < 64; i++) exp_q.push_back(0);
        send_block(64, -1, 0);
        compare_outputs("dc", s0_edge + 65);

        // ---- 2: ramp block ----
        clear_all();
        for (int k = 0; k < 64; k++) cur_blk[k] = k;
        expect_block();
        send_block(64, -1, 0);
        compare_outputs("ramp", s0_edge + 65);
        if (cap_q.size() > 3) begin
            check("ramp out1", cap_q[1].data, 0);
            check("ramp out2", cap_q[2].data, 1);
            check("ramp out3", cap_q[3].data, 1);
        end else begin
            check("ramp short", cap_q.size(), 64);
        end

        // ---- 3: rounding / sign vectors, back-to-back DC blocks ----
        clear_all();
        first_s0 = 0;
        for (int v = 0; v < 10; v++) begin
            for (int k = 0; k < 64; k++) cur_blk[k] = 0;
            cur_blk[0] = vecs[v].c;
            exp_q.push_back(vecs[v].exp0);
            for (int i = 1; i < 64; i++) exp_q.push_back(0);
            send_block(64, -1, 0);
            if (v == 0) first_s0 = s0_edge;
        end
        compare_outputs("vec", first_s0 + 65);

        // ---- 4: two random blocks, contiguous ----
        clear_all();
        first_s0 = 0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 64; k++) cur_blk[k] = rnd_coef();
            expect_block();
            send_block(64, -1, 0);
            if (b == 0) first_s0 = s0_edge;
        end
        compare_outputs("two_blk", first_s0 + 65);

        // ---- random blocks with extremes sprinkled in ----
        clear_all();
        first_s0 = 0;
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 64; k++) begin
                case ($urandom_range(7, 0))
                    0:       cur_blk[k] = -2048;
                    1:       cur_blk[k] = 2047;
                    2:       cur_blk[k] = int'($urandom_range(60, 0)) - 30;
                    default: cur_blk[k] = rnd_coef();
                endcase
            end
            expect_block();
            send_block(64, -1, 0);
            if (b == 0) first_s0 = s0_edge;
        end
        compare_outputs("rand", first_s0 + 65);

        // ---- 5: enb gap of 5 after sample 30 ----
        clear_all();
        for (int k = 0; k < 64; k++) cur_blk[k] = rnd_coef();
        expect_block();
        send_block(64, 30, 5);
        compare_outputs("gap", s0_edge + 70);

        // ---- 6: asynchronous reset mid-output, partial block discarded ----
        clear_all();
        for (int k = 0; k < 64; k++) cur_blk[k] = k * 7 - 200;
        send_block(64, -1, 0);
        for (int k = 0; k < 64; k++) cur_blk[k] = rnd_coef();
        send_block(20, -1, 0);
        @(posedge clk);
        #2;
        check("rst pre out_valid", int'(out_valid), 1);
        rst = 1'b1;
        enb = 1'b0;
        #1;
        check("rst async out_valid", int'(out_valid), 0);
        check("rst async data_out", int'(data_out), 0);
        check("rst async blk_start", int'(blk_start), 0);
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        clear_all();
        for (int k = 0; k < 64; k++) cur_blk[k] = rnd_coef();
        expect_block();
        send_block(64, -1, 0);
        compare_outputs("post_rst", s0_edge + 65);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
